debounce_sync: RTL and testbench
================================

Name: debounce_sync

Overview:
- Conditions a raw asynchronous level input, such as a push-button or switch, before it drives the data input of the d_ff stage.
- Synchronises the input into the clk domain through a flop chain.
- Filters bounce by requiring STABLE_CYCLES consecutive equal samples.
- Outputs a clean level plus single-cycle rise and fall pulses for downstream registers and counters.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops (legal range 2..4)
STABLE_CYCLES, 16, consecutive synchronised samples required to accept a new level (must be >= 2)
CNT_WIDTH, 8, stability counter width; must hold STABLE_CYCLES-1

Ports:
clk  input  1  rising-edge clock, sole clock domain
reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk
btn_in  input  1  raw asynchronous input level
btn_db  output  1  debounced level; intended to drive d of d_ff
rise_pulse  output  1  one-cycle high when btn_db goes 0->1
fall_pulse  output  1  one-cycle high when btn_db goes 1->0

Behaviour:
- One clock, clk. Reset is synchronous and active-low.
- Reset has priority over all other logic. When reset=0 at a rising edge:
  - all synchroniser flops <= 0
  - state <= IDLE_LOW
  - cnt <= 0
  - btn_db, rise_pulse and fall_pulse <= 0
- Synchroniser: btn_in shifts through SYNC_STAGES flops. s denotes the last flop.
- FSM states and transitions on each rising edge, reset deasserted:
  - IDLE_LOW:
    - s=1 -> WAIT_HIGH, cnt <= 1
    - else stay, cnt <= 0
  - WAIT_HIGH:
    - s=0 -> IDLE_LOW, cnt <= 0, no pulse (bounce rejected)
    - s=1 and cnt==STABLE_CYCLES-1 -> IDLE_HIGH, btn_db <= 1, rise_pulse <= 1, cnt <= 0
    - else cnt <= cnt+1
  - IDLE_HIGH: mirror of IDLE_LOW with s=0 -> WAIT_LOW.
  - WAIT_LOW: mirror of WAIT_HIGH. Completion sets btn_db <= 0, fall_pulse <= 1.
- Pulses are registered and high for exactly one cycle. They clear on the next edge unconditionally.
- rise_pulse and fall_pulse are never high in the same cycle.
- Latency: let edge k be the first edge at which the first sync flop captures the new btn_in level. Given a clean, held input:
  - btn_db and the corresponding pulse update at edge k+SYNC_STAGES+STABLE_CYCLES-1.
  - With the defaults this is edge k+17.
- Boundaries:
  - An input glitch shorter than STABLE_CYCLES samples at s produces no output change.
  - cnt never exceeds STABLE_CYCLES-1 and never wraps.
  - Reset asserted during WAIT_* aborts the transition: no pulse, btn_db=0.
  - btn_in held 1 through reset release is accepted as a new press after the full latency. rise_pulse fires.
- Unknown or illegal state encodings recover to IDLE_LOW with outputs 0.

Optional Feature:
- Macro: DEBOUNCE_PRESS_COUNT_EN
- Defined:
  - Adds output press_count [7:0].
  - press_count increments by 1 at the same edge rise_pulse is set.
  - It wraps 255 -> 0.
  - It resets to 0 on reset=0.
  - It is unaffected by fall events and by rejected bounces.
- Undefined:
  - The port and its register are absent.
  - All other behaviour is identical.

Test Plan:
All scenarios use SYNC_STAGES=2, STABLE_CYCLES=4, clk period 10. Inputs change on negedge.
1. Reset with btn_in=1: hold reset=0 for 3 edges -> btn_db=0, rise_pulse=0, fall_pulse=0 throughout. After release, rise_pulse is high for exactly 1 cycle at the 5th edge after the first capture edge, and btn_db=1 thereafter.
2. Clean press: btn_in 0->1, held 10 cycles -> btn_db rises at edge k+5. rise_pulse is high for one cycle at the same edge. fall_pulse stays 0.
3. Bounce rejection: from idle low, btn_in=1 for 3 cycles then 0 -> btn_db stays 0, no pulses, FSM returns to IDLE_LOW.
4. Release: from btn_db=1, btn_in 1->0 held -> btn_db falls at edge k+5 with a one-cycle fall_pulse. A 1-cycle high glitch during WAIT_LOW restarts the count, so the fall moves out by the glitch length plus re-qualification.
5. Reset mid-wait: btn_in=1, assert reset=0 at edge k+3 -> no rise_pulse ever for that press; btn_db=0. After release, the press requalifies with full latency.
6. DEBOUNCE_PRESS_COUNT_EN defined:
   - 3 clean presses -> press_count=3.
   - 256 clean presses from reset -> press_count=0 (wrap).
   - 2 rejected bounces -> no increment.

Source files
------------

// File: rtl/debounce_sync_if.sv
// Debouncer signal bundle: raw button level in, clean level and edge pulses out.
// DEBOUNCE_PRESS_COUNT_EN adds the press_count bus.
interface debounce_sync_if;
    logic       btn_in;
    logic       btn_db;
    logic       rise_pulse;
    logic       fall_pulse;
`ifdef DEBOUNCE_PRESS_COUNT_EN
    logic [7:0] press_count;
`endif

    modport master (
        output btn_in,
`ifdef DEBOUNCE_PRESS_COUNT_EN
        input  press_count,
`endif
        input  btn_db,
        input  rise_pulse,
        input  fall_pulse
    );

    modport slave (
        input  btn_in,
`ifdef DEBOUNCE_PRESS_COUNT_EN
        output press_count,
`endif
        output btn_db,
        output rise_pulse,
        output fall_pulse
    );
endinterface

// File: rtl/debounce_sync.sv
// Synchroniser plus stability-counting debouncer with registered edge pulses.
// Optional DEBOUNCE_PRESS_COUNT_EN adds an 8-bit wrapping press counter.
module debounce_sync #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_WIDTH     = 8
) (
    input  logic            clk,
    input  logic            reset,
    debounce_sync_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE_LOW,
        WAIT_HIGH,
        IDLE_HIGH,
        WAIT_LOW
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    state_t                 state;
    logic [CNT_WIDTH-1:0]   cnt;
    logic                   btn_db;
    logic                   rise_pulse;
    logic                   fall_pulse;
`ifdef DEBOUNCE_PRESS_COUNT_EN
    logic [7:0]             press_count;
`endif

    // Shift the raw level through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], bus.btn_in};
        end
    end

    assign s = sync[SYNC_STAGES-1];

    // Qualify level changes; a contrary sample during a wait restarts from idle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE_LOW;
            cnt        <= '0;
            btn_db     <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
`ifdef DEBOUNCE_PRESS_COUNT_EN
            press_count <= '0;
`endif
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            case (state)
                IDLE_LOW: begin
                    if (s) begin
                        state <= WAIT_HIGH;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt   <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!s) begin
                        state <= IDLE_LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state      <= IDLE_HIGH;
                        btn_db     <= 1'b1;
                        rise_pulse <= 1'b1;
                        cnt        <= '0;
`ifdef DEBOUNCE_PRESS_COUNT_EN
                        press_count <= press_count + 8'd1;
`endif
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                IDLE_HIGH: begin
                    if (!s) begin
                        state <= WAIT_LOW;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt   <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (s) begin
                        state <= IDLE_HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state      <= IDLE_LOW;
                        btn_db     <= 1'b0;
                        fall_pulse <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state  <= IDLE_LOW;
                    cnt    <= '0;
                    btn_db <= 1'b0;
                end
            endcase
        end
    end

    assign bus.btn_db     = btn_db;
    assign bus.rise_pulse = rise_pulse;
    assign bus.fall_pulse = fall_pulse;
`ifdef DEBOUNCE_PRESS_COUNT_EN
    assign bus.press_count = press_count;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync with SYNC_STAGES=2, STABLE_CYCLES=4.
// Covers DEBOUNCE_PRESS_COUNT_EN when that macro is defined.
module tb_debounce_sync;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    debounce_sync_if bif();

    debounce_sync #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (4),
        .CNT_WIDTH     (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Cycle i: drive in[i] at negedge, check outputs #1 after the next posedge.
    task automatic run(input string tag, input int n, input logic [31:0] in,
                       input logic [31:0] db, input logic [31:0] rp,
                       input logic [31:0] fp);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bif.btn_in = in[i];
            @(posedge clk);
            #1;
            chk($sformatf("%s db c%0d", tag, i), 32'(bif.btn_db), 32'(db[i]));
            chk($sformatf("%s rise c%0d", tag, i), 32'(bif.rise_pulse), 32'(rp[i]));
            chk($sformatf("%s fall c%0d", tag, i), 32'(bif.fall_pulse), 32'(fp[i]));
        end
    endtask

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bif.btn_in = v;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rst_ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s db r%0d", tag, i), 32'(bif.btn_db), 32'd0);
            chk($sformatf("%s rise r%0d", tag, i), 32'(bif.rise_pulse), 32'd0);
            chk($sformatf("%s fall r%0d", tag, i), 32'(bif.fall_pulse), 32'd0);
        end
    endtask

    initial begin
        bif.btn_in = 1'b1;
        reset      = 1'b0;
        rst_ticks("rst_hold", 3);
        reset = 1'b1;
        run("rst_rel", 8, 32'hFF, 32'hE0, 32'h20, 32'h0);

        run("release", 10, 32'h0, 32'h1F, 32'h0, 32'h20);
        run("press", 10, 32'h3FF, 32'h3E0, 32'h20, 32'h0);
        run("glitch_rel", 12, 32'h4, 32'hFF, 32'h0, 32'h100);

        run("bounce", 12, 32'h7, 32'h0, 32'h0, 32'h0);
        run("press2", 10, 32'h3FF, 32'h3E0, 32'h20, 32'h0);
        run("rel2", 10, 32'h0, 32'h1F, 32'h0, 32'h20);

        run("pre_rst", 3, 32'h7, 32'h0, 32'h0, 32'h0);
        reset = 1'b0;
        rst_ticks("mid_rst", 2);
        reset = 1'b1;
        run("requal", 8, 32'hFF, 32'hE0, 32'h20, 32'h0);
        run("rel3", 10, 32'h0, 32'h1F, 32'h0, 32'h20);

`ifdef DEBOUNCE_PRESS_COUNT_EN
        reset = 1'b0;
        rst_ticks("pc_rst", 1);
        chk("pc_reset", 32'(bif.press_count), 32'd0);
        reset = 1'b1;
        for (int p = 0; p < 3; p++) begin
            run("pc_press", 8, 32'hFF, 32'hE0, 32'h20, 32'h0);
            run("pc_rel", 8, 32'h0, 32'h1F, 32'h0, 32'h20);
        end
        chk("pc_three", 32'(bif.press_count), 32'd3);
        run("pc_bounce1", 10, 32'h7, 32'h0, 32'h0, 32'h0);
        run("pc_bounce2", 10, 32'h3, 32'h0, 32'h0, 32'h0);
        chk("pc_bounce", 32'(bif.press_count), 32'd3);

        reset = 1'b0;
        rst_ticks("pc_rst2", 1);
        reset = 1'b1;
        for (int p = 0; p < 255; p++) begin
            hold(1'b1, 7);
            hold(1'b0, 7);
        end
        chk("pc_255", 32'(bif.press_count), 32'd255);
        hold(1'b1, 7);
        hold(1'b0, 7);
        chk("pc_wrap", 32'(bif.press_count), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
